// File: rtl/regb_fifo_packer.sv
// regb_fifo_packer
// Drain-side consumer of the register-based shift FIFO. It pops WIDTH-bit
// words from the FIFO head and packs RATIO consecutive words into one wide
// word. The wide word is then offered downstream with a valid/ack handshake.
//
// Ports
//   clk            single clock, rising edge
//   res_n          asynchronous active-low reset
//   fifo_data      FIFO head word (valid while fifo_empty_n=1)
//   fifo_empty_n   FIFO head holds a valid word
//   fifo_shift_out pop strobe (combinational); FIFO drops its head on this edge
//   flush          emit a partially filled word (ignored when nothing is captured)
//   out_data       packed word; the first popped word sits in bits [WIDTH-1:0]
//   out_count      number of valid words in out_data
//   out_valid      out_data/out_count are valid and held until out_ack
//   out_ack        downstream accepts the word (only while out_valid=1)

// One packing slot. It loads on its write strobe and clears when the held
// word is acknowledged, so slots that have not been written always read 0.
module regb_fifo_packer_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             wr,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)   q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= din;
    end
endmodule

module regb_fifo_packer #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [WIDTH-1:0]           fifo_data,
    input  logic                       fifo_empty_n,
    output logic                       fifo_shift_out,
    input  logic                       flush,
    output logic [WIDTH*RATIO-1:0]     out_data,
    output logic [$clog2(RATIO+1)-1:0] out_count,
    output logic                       out_valid,
    input  logic                       out_ack
);
    localparam int CW = $clog2(RATIO+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_nxt;
    logic                         pop;
    logic                         clr;
    logic [RATIO-1:0][WIDTH-1:0]  slots;

    // Gating with res_n keeps the FIFO from being popped while reset is held,
    // even before the asynchronous reset has forced the state to FILL.
    assign pop            = (state == FILL) & fifo_empty_n & res_n;
    assign fifo_shift_out = pop;
    assign cnt_nxt        = cnt + CW'(pop);
    assign clr            = (state == HOLD) & out_ack;
    assign out_data       = slots;

    // Each slot captures when it is the current fill position, so the pop
    // and its capture happen on the same edge.
    for (genvar i = 0; i < RATIO; i++) begin : g_slot
        regb_fifo_packer_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .res_n (res_n),
            .wr    (pop && (cnt == CW'(i))),
            .clr   (clr),
            .din   (fifo_data),
            .q     (slots[i])
        );
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= FILL;
            cnt       <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    cnt <= cnt_nxt;
                    // A pop on the flush edge is counted before deciding;
                    // a flush with nothing captured is dropped.
                    if ((cnt_nxt == CW'(RATIO)) || (flush && (cnt_nxt != '0))) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_count <= cnt_nxt;
                    end
                end
                HOLD: begin
                    // Returning to FILL here yields the one-cycle bubble:
                    // the next pop can only happen on the following edge.
                    if (out_ack) begin
                        state     <= FILL;
                        cnt       <= '0;
                        out_count <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regb_fifo_packer.sv
module tb_regb_fifo_packer;
    localparam int WIDTH = 4;
    localparam int RATIO = 4;
    localparam int CW    = $clog2(RATIO+1);

    logic                   clk = 1'b0;
    logic                   res_n;
    logic [WIDTH-1:0]       fifo_data;
    logic                   fifo_empty_n;
    logic                   fifo_shift_out;
    logic                   flush;
    logic [WIDTH*RATIO-1:0] out_data;
    logic [CW-1:0]          out_count;
    logic                   out_valid;
    logic                   out_ack;

    regb_fifo_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk            (clk),
        .res_n          (res_n),
        .fifo_data      (fifo_data),
        .fifo_empty_n   (fifo_empty_n),
        .fifo_shift_out (fifo_shift_out),
        .flush          (flush),
        .out_data       (out_data),
        .out_count      (out_count),
        .out_valid      (out_valid),
        .out_ack        (out_ack)
    );

    always #5 clk = ~clk;

    // FIFO model: written by the stimulus, drained by the DUT's pop strobe.
    logic [WIDTH-1:0] fifo_mem [0:255];
    logic [7:0]       wr_ptr = '0;
    logic [7:0]       rd_ptr = '0;
    int               pops   = 0;

    assign fifo_empty_n = (rd_ptr != wr_ptr);
    assign fifo_data    = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_shift_out) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_pops(input int target, input string name);
        int k = 0;
        while (pops < target && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_pops"}, pops, target);
    endtask

    task automatic ack_word(input string name);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk({name, "_valid_after_ack"}, 32'(out_valid), 32'd0);
        chk({name, "_data_after_ack"},  32'(out_data),  32'd0);
    endtask

    typedef struct {
        logic [WIDTH-1:0]       w [RATIO];
        int                     n;
        logic [WIDTH*RATIO-1:0] exp_data;
        int                     exp_count;
    } vec_t;

    typedef struct {
        logic [WIDTH*RATIO-1:0] data;
        int                     count;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];

    initial begin
        exp_t e;
        logic [WIDTH*RATIO-1:0] held;
        int base;

        vecs[0] = '{w: '{4'hA, 4'hB, 4'h0, 4'h0}, n: 2, exp_data: 16'h00BA, exp_count: 2};
        vecs[1] = '{w: '{4'hF, 4'hE, 4'hD, 4'hC}, n: 4, exp_data: 16'hCDEF, exp_count: 4};
        vecs[2] = '{w: '{4'h7, 4'h0, 4'h0, 4'h0}, n: 1, exp_data: 16'h0007, exp_count: 1};
        vecs[3] = '{w: '{4'h9, 4'h8, 4'h7, 4'h0}, n: 3, exp_data: 16'h0789, exp_count: 3};
        vecs[4] = '{w: '{4'h0, 4'h0, 4'h0, 4'h0}, n: 4, exp_data: 16'h0000, exp_count: 4};

        res_n   = 1'b0;
        flush   = 1'b0;
        out_ack = 1'b0;
        // Words for the full pack plus the first word of the flush+pop case.
        push(4'h1); push(4'h2); push(4'h3); push(4'h4); push(4'h5);
        repeat (3) @(negedge clk);
        chk("rst_shift_out", 32'(fifo_shift_out), 32'd0);
        chk("rst_valid",     32'(out_valid),      32'd0);
        chk("rst_data",      32'(out_data),       32'd0);
        chk("rst_count",     32'(out_count),      32'd0);
        chk("rst_no_pops",   pops,                0);

        // Full pack
        res_n = 1'b1;
        wait_valid("full");
        chk("full_pops",      pops,                4);
        chk("full_data",      32'(out_data),       32'h4321);
        chk("full_count",     32'(out_count),      32'd4);
        chk("full_shift_out", 32'(fifo_shift_out), 32'd0);

        // Backpressure: held word stays put, no pops
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data",  32'(out_data),  32'(held));
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        chk("bp_pops", pops, 4);
        ack_word("bp");
        chk("bubble_pops",      pops,                4);
        chk("bubble_shift_out", 32'(fifo_shift_out), 32'd1);
        @(negedge clk);
        chk("resume_pops", pops, 5);

        // Flush on the same edge as the second pop (0x5 already captured)
        push(4'h6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fpop_valid", 32'(out_valid), 32'd1);
        chk("fpop_data",  32'(out_data),  32'h0065);
        chk("fpop_count", 32'(out_count), 32'd2);
        ack_word("fpop");

        // Flush with nothing captured and FIFO empty
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("flush0_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Table-driven vectors through the scoreboard
        for (int v = 0; v < 5; v++) begin
            base = pops;
            sb.push_back('{data: vecs[v].exp_data, count: vecs[v].exp_count});
            for (int j = 0; j < vecs[v].n; j++) push(vecs[v].w[j]);
            if (vecs[v].n < RATIO) begin
                wait_pops(base + vecs[v].n, "vec");
                chk("vec_not_early", 32'(out_valid), 32'd0);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            wait_valid("vec");
            e = sb.pop_front();
            chk("vec_data",      32'(out_data),       32'(e.data));
            chk("vec_count",     32'(out_count),      32'(e.count));
            chk("vec_shift_out", 32'(fifo_shift_out), 32'd0);
            chk("vec_pops",      pops,                base + vecs[v].n);
            ack_word("vec");
        end

        // Reset mid-fill
        base = pops;
        push(4'h1); push(4'h2); push(4'h3);
        wait_pops(base + 3, "mid");
        #1 res_n = 1'b0;
        #1;
        chk("mid_rst_data",  32'(out_data),       32'd0);
        chk("mid_rst_valid", 32'(out_valid),      32'd0);
        chk("mid_rst_count", 32'(out_count),      32'd0);
        chk("mid_rst_shift", 32'(fifo_shift_out), 32'd0);
        #1 res_n = 1'b1;
        base = pops;
        push(4'hD); push(4'hC); push(4'hB); push(4'hA);
        wait_valid("post_rst");
        chk("post_rst_data",  32'(out_data),  32'hABCD);
        chk("post_rst_count", 32'(out_count), 32'd4);
        chk("post_rst_pops",  pops,           base + 4);
        ack_word("post_rst");
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
